// File: rtl/l2_mem_responder.sv
// L2 request responder: accepts one word-granular LOAD/STORE at a time,
// waits LATENCY cycles, then pulses l2_req_fulfilled. Backed by a
// word-addressed array whose contents survive reset.

package xentry_pkg;
  typedef enum logic [1:0] {
    MO_UNKNOWN = 2'd0,
    LOAD       = 2'd1,
    STORE      = 2'd2
  } memory_operation_e;
endpackage

module l2_mem_responder
  import xentry_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int XLEN            = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l2_req_valid,
  input  memory_operation_e     l2_req_type,
  input  logic [ADDR_WIDTH-1:0] l2_req_addr,
  input  logic [XLEN-1:0]       l2_req_wdata,
  output logic                  l2_req_fulfilled,
  output logic [XLEN-1:0]       l2_rdata,
  output logic                  busy,
  output logic                  protocol_error
);

  localparam int IW = $clog2(MEM_DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     idx_q;
  memory_operation_e type_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   mem_q [MEM_DEPTH_WORDS];

  logic [IW-1:0] req_idx;
  logic          req_type_ok;
  logic          addr_unused;

  // Upper address bits and the byte offset are deliberately ignored (aliasing).
  assign addr_unused = ^l2_req_addr;
  assign req_idx     = l2_req_addr[2 +: IW];
  assign req_type_ok = (l2_req_type == LOAD) || (l2_req_type == STORE);

  // Request FSM with registered Moore outputs; for LATENCY==1 the idle
  // state jumps straight to respond and preloads the outputs on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      idx_q            <= '0;
      type_q           <= MO_UNKNOWN;
      wdata_q          <= '0;
      l2_req_fulfilled <= 1'b0;
      l2_rdata         <= '0;
      busy             <= 1'b0;
      protocol_error   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          l2_req_fulfilled <= 1'b0;
          if (l2_req_valid) begin
            if (req_type_ok) begin
              idx_q   <= req_idx;
              type_q  <= l2_req_type;
              wdata_q <= l2_req_wdata;
              cnt_q   <= CW'(LATENCY - 1);
              busy    <= 1'b1;
              if (LATENCY == 1) begin
                state_q          <= ST_RESPOND;
                l2_req_fulfilled <= 1'b1;
                if (l2_req_type == LOAD) l2_rdata <= mem_q[req_idx];
              end else begin
                state_q <= ST_WAIT;
              end
            end else begin
              protocol_error <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q          <= ST_RESPOND;
            l2_req_fulfilled <= 1'b1;
            if (type_q == LOAD) l2_rdata <= mem_q[idx_q];
          end
        end
        ST_RESPOND: begin
          state_q          <= ST_IDLE;
          l2_req_fulfilled <= 1'b0;
          busy             <= 1'b0;
        end
        default: begin
          state_q          <= state_e'('x);
          cnt_q            <= 'x;
          l2_req_fulfilled <= 1'bx;
          l2_rdata         <= 'x;
          busy             <= 1'bx;
          protocol_error   <= 1'bx;
        end
      endcase
    end
  end

  // Store commit at the end of the respond cycle; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_RESPOND && type_q == STORE) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: dut0 runs LATENCY=4, dut1 LATENCY=1.
// Drivers push expected pulses into per-DUT queues; a negedge monitor pops
// and compares pulse timing, load data, busy and protocol_error.

module tb_l2_mem_responder;
  import xentry_pkg::*;

  typedef struct packed {
    int unsigned acc;
    int unsigned due;
    logic [31:0] rdata;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst      [2];
  logic              valid    [2];
  memory_operation_e typ      [2];
  logic [31:0]       addr     [2];
  logic [31:0]       wdata    [2];
  logic [31:0]       rdata    [2];
  logic              ful      [2];
  logic              busy     [2];
  logic              perr     [2];
  logic              exp_perr [2];
  logic [31:0]       last_rd  [2];

  exp_t q0[$];
  exp_t q1[$];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_mem_responder #(.ADDR_WIDTH(32), .XLEN(32), .MEM_DEPTH_WORDS(1024), .LATENCY(4)) dut0 (
    .clk(clk), .reset(rst[0]), .l2_req_valid(valid[0]), .l2_req_type(typ[0]),
    .l2_req_addr(addr[0]), .l2_req_wdata(wdata[0]), .l2_req_fulfilled(ful[0]),
    .l2_rdata(rdata[0]), .busy(busy[0]), .protocol_error(perr[0]));

  l2_mem_responder #(.ADDR_WIDTH(32), .XLEN(32), .MEM_DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst[1]), .l2_req_valid(valid[1]), .l2_req_type(typ[1]),
    .l2_req_addr(addr[1]), .l2_req_wdata(wdata[1]), .l2_req_fulfilled(ful[1]),
    .l2_rdata(rdata[1]), .busy(busy[1]), .protocol_error(perr[1]));

  function automatic int unsigned lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic qflush(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  // Monitor: compare every cycle against the head of the expectation queue.
  task automatic mon(input int d);
    exp_t head;
    bit   have;
    logic ef, eb;
    have = 1'b0;
    head = '0;
    if (qsize(d) != 0) begin
      have = 1'b1;
      head = (d == 0) ? q0[0] : q1[0];
    end
    ef = have && (cyc == head.due);
    eb = have && (cyc > head.acc);
    chk("fulfilled", d, {31'b0, ful[d]}, {31'b0, ef});
    chk("busy", d, {31'b0, busy[d]}, {31'b0, eb});
    chk("protocol_error", d, {31'b0, perr[d]}, {31'b0, exp_perr[d]});
    if (ef) begin
      chk("rdata", d, rdata[d], head.rdata);
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  // Issue one request in the current cycle and wait (bounded) for its pulse.
  task automatic req(input int d, input memory_operation_e t, input logic [31:0] a,
                     input logic [31:0] w, input logic [31:0] exp_rd, input bit drop);
    exp_t e;
    valid[d] = 1'b1;
    typ[d]   = t;
    addr[d]  = a;
    wdata[d] = w;
    e.acc    = cyc;
    e.due    = cyc + lat(d);
    if (t == LOAD) last_rd[d] = exp_rd;
    e.rdata  = last_rd[d];
    qpush(d, e);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (drop && n == 0) valid[d] = 1'b0;
      if (qsize(d) == 0) break;
    end
    if (qsize(d) != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d addr %h: pulse not seen, expected at cycle %0d", d, a, e.due);
      qflush(d);
    end
  endtask

  task automatic do_reset(input int d);
    rst[d]   = 1'b1;
    valid[d] = 1'b0;
    @(posedge clk);
    #1;
    rst[d]      = 1'b0;
    qflush(d);
    last_rd[d]  = '0;
    exp_perr[d] = 1'b0;
    chk("reset_rdata", d, rdata[d], 32'h0);
  endtask

  initial begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; typ[d] = MO_UNKNOWN;
      addr[d] = '0; wdata[d] = '0; exp_perr[d] = 1'b0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk("reset_rdata", 0, rdata[0], 32'h0);
    chk("reset_rdata", 1, rdata[1], 32'h0);

    // Store then back-to-back load of the same word.
    req(0, STORE, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    req(0, LOAD,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Address aliasing: 0x1000 wraps to word 0; high bits of 0xFFFFF010 hit word 4.
    req(0, STORE, 32'h1000, 32'hA5A50001, 32'h0, 1'b0);
    req(0, LOAD,  32'h0000, 32'h0, 32'hA5A50001, 1'b0);
    req(0, LOAD,  32'hFFFFF013, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset while a store is waiting: store discarded, no pulse.
    req(0, STORE, 32'h20, 32'h11112222, 32'h0, 1'b0);
    valid[0] = 1'b1; typ[0] = STORE; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    e.acc = cyc; e.due = cyc + 4; e.rdata = last_rd[0];
    qpush(0, e);
    repeat (2) begin @(posedge clk); #1; end
    do_reset(0);
    repeat (6) begin @(posedge clk); #1; end
    req(0, LOAD, 32'h20, 32'h0, 32'h11112222, 1'b0);

    // Illegal request types: not accepted, sticky error, later load still served.
    valid[0] = 1'b1; typ[0] = MO_UNKNOWN; addr[0] = 32'h10;
    @(posedge clk); #1;
    exp_perr[0] = 1'b1;
    typ[0] = memory_operation_e'(2'b11);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    req(0, LOAD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Valid dropped right after acceptance: store still completes.
    req(0, STORE, 32'h40, 32'hCAFEF00D, 32'h0, 1'b1);
    req(0, LOAD,  32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
    valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    do_reset(0);

    // LATENCY=1: preload eight words, then eight loads with valid held high.
    for (int i = 0; i < 8; i++)
      req(1, STORE, 32'(i * 4), 32'hC0DE0000 | 32'(i * 32'h0101), 32'h0, 1'b0);
    for (int i = 0; i < 8; i++)
      req(1, LOAD, 32'(i * 4), 32'h0, 32'hC0DE0000 | 32'(i * 32'h0101), 1'b0);
    valid[1] = 1'b0;

    repeat (4) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
